// File: rtl/cp0_exception_unit_pkg.sv
// Shared constants for the CP0 exception unit: exception codes, register
// numbers, field positions and the writable-bit masks.
package cp0_exception_unit_pkg;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int IM_LSB       = 10;
  localparam int IM_MSB       = 15;
  localparam int CAUSE_BD_BIT = 31;
  localparam int EXC_LSB      = 2;
  localparam int EXC_MSB      = 6;

  // Only IM, EXL and IE survive a write to SR.
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational trap decision: interrupt/exception request and the ExcCode
// to record. Interrupts win over a simultaneous exception.
module cp0_req_gen
  import cp0_exception_unit_pkg::*;
(
  input  logic [5:0] i_hw_int,
  input  logic [5:0] i_im,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_exc_req,
  output logic       o_req,
  output logic [4:0] o_cause_code
);

  always_comb begin
    o_int_req    = (|(i_hw_int & i_im)) & i_ie & ~i_exl;
    o_exc_req    = (i_exc_code != EXC_INT) & ~i_exl;
    o_req        = o_int_req | o_exc_req;
    o_cause_code = o_int_req ? EXC_INT : i_exc_code;
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 beside the M stage: holds SR/Cause/EPC, decides traps,
// drives the flush/redirect request and serves mfc0/mtc0/eret.
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h2021_0707,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  logic [31:0] r_sr;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [4:0]  w_cause_code;
  logic [31:0] w_sr_next;
  logic [31:0] w_cause;
  logic [31:0] w_trap_epc;

  cp0_req_gen u_req_gen (
    .i_hw_int     (hw_int),
    .i_im         (r_sr[IM_MSB:IM_LSB]),
    .i_ie         (r_sr[SR_IE_BIT]),
    .i_exl        (r_sr[SR_EXL_BIT]),
    .i_exc_code   (exc_code_in),
    .o_int_req    (w_int_req),
    .o_exc_req    (w_exc_req),
    .o_req        (w_req),
    .o_cause_code (w_cause_code)
  );

  // A trap sets EXL and discards any mtc0; otherwise eret beats an SR write for EXL.
  always_comb begin
    w_sr_next = r_sr;
    if (w_req) begin
      w_sr_next[SR_EXL_BIT] = 1'b1;
    end else begin
      if (we && cp0_addr == CP0_SR)
        w_sr_next = cp0_wdata & SR_WMASK;
      if (exl_clr)
        w_sr_next[SR_EXL_BIT] = 1'b0;
    end
  end

  assign w_trap_epc = word_align(bd_in ? (vpc - 32'd4) : vpc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr      <= '0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_sr <= w_sr_next;
      r_ip <= hw_int;
      if (w_req) begin
        r_bd      <= bd_in;
        r_exccode <= w_cause_code;
        r_epc     <= w_trap_epc;
      end else if (we && cp0_addr == CP0_EPC) begin
        r_epc <= word_align(cp0_wdata);
      end
    end
  end

  always_comb begin
    w_cause                        = '0;
    w_cause[CAUSE_BD_BIT]          = r_bd;
    w_cause[IM_MSB:IM_LSB]         = r_ip;
    w_cause[EXC_MSB:EXC_LSB]       = r_exccode;
    case (cp0_addr)
      CP0_SR:    cp0_rdata = r_sr;
      CP0_CAUSE: cp0_rdata = w_cause;
      CP0_EPC:   cp0_rdata = r_epc;
      CP0_PRID:  cp0_rdata = PRID;
      default:   cp0_rdata = 32'h0;
    endcase
  end

  assign req        = w_req & ~reset;
  assign handler_pc = HANDLER_PC;
  assign epc_out    = r_epc;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed-vector bench for cp0_exception_unit with hand-computed expectations.
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int n_checks = 0;
  int n_errors = 0;

  cp0_exception_unit dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .cp0_rdata   (cp0_rdata),
    .vpc         (vpc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .exl_clr     (exl_clr),
    .req         (req),
    .handler_pc  (handler_pc),
    .epc_out     (epc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    cp0_addr = addr;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic idle();
    we = 1'b0; exl_clr = 1'b0; exc_code_in = 5'd0; bd_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle(); cp0_addr = 5'd0; cp0_wdata = '0; vpc = '0; hw_int = '0;
    exc_code_in = 5'd12;
    tick(); tick();
    chk("req_in_reset", {31'd0, req}, 32'd0);
    rd(5'd15, 32'h2021_0707, "prid_in_reset");
    reset = 1'b0; idle();
    tick();
    rd(5'd12, 32'h0, "sr_rst");
    rd(5'd13, 32'h0, "cause_rst");
    rd(5'd14, 32'h0, "epc_rst");
    rd(5'd15, 32'h2021_0707, "prid");
    rd(5'd3,  32'h0, "unmapped");
    chk("handler_pc", handler_pc, 32'h0000_4180);

    // mtc0 SR all ones: masked; old value visible during the write
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF;
    #1 chk("sr_rdw_old", cp0_rdata, 32'h0);
    tick(); we = 1'b0;
    rd(5'd12, 32'h0000_FC03, "sr_mask");
    we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    tick(); we = 1'b0;
    rd(5'd13, 32'h0, "cause_ro");
    we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0; exl_clr = 1'b1;
    tick(); idle();
    rd(5'd12, 32'h0, "sr_cleared");

    // Ov trap
    exc_code_in = 5'd12; vpc = 32'h0000_3010; bd_in = 1'b0;
    #1 chk("ov_req", {31'd0, req}, 32'd1);
    tick();
    exc_code_in = 5'd4; vpc = 32'h0000_3090;
    #1 chk("nest_req", {31'd0, req}, 32'd0);
    rd(5'd14, 32'h0000_3010, "ov_epc");
    rd(5'd13, 32'h0000_0030, "ov_cause");
    rd(5'd12, 32'h0000_0002, "ov_exl");
    tick();
    rd(5'd14, 32'h0000_3010, "nest_epc_hold");
    rd(5'd13, 32'h0000_0030, "nest_cause_hold");

    // AdES in delay slot
    idle(); exl_clr = 1'b1;
    tick(); idle();
    vpc = 32'h0000_3020; bd_in = 1'b1; exc_code_in = 5'd5;
    #1 chk("ades_req", {31'd0, req}, 32'd1);
    tick(); idle();
    rd(5'd14, 32'h0000_301C, "ades_epc");
    rd(5'd13, 32'h8000_0014, "ades_cause");

    // Interrupt beats exception
    exl_clr = 1'b1; we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    tick(); idle();
    rd(5'd12, 32'h0000_0401, "sr_int_en");
    hw_int = 6'b000001; exc_code_in = 5'd10; vpc = 32'h0000_3040;
    #1 chk("int_req", {31'd0, req}, 32'd1);
    tick();
    #1 chk("int_nest_req", {31'd0, req}, 32'd0);
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd14, 32'h0000_3040, "int_epc");

    // Same stimulus with IE = 0: exception code recorded
    idle(); hw_int = 6'b000001;
    exl_clr = 1'b1; we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0400;
    tick(); idle();
    rd(5'd12, 32'h0000_0400, "sr_ie_off");
    exc_code_in = 5'd10; vpc = 32'h0000_3044;
    #1 chk("ri_req", {31'd0, req}, 32'd1);
    tick(); idle();
    rd(5'd13, 32'h0000_0428, "ri_cause");

    // eret with concurrent SR write: exl_clr wins for EXL
    hw_int = 6'b000000;
    exl_clr = 1'b1; we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403;
    tick(); idle();
    rd(5'd12, 32'h0000_0401, "eret_sr");
    rd(5'd13, 32'h0000_0028, "ip_follows");

    // mtc0 EPC aligns low bits
    we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007;
    tick(); idle();
    chk("epc_wr_align", epc_out, 32'h0000_3004);

    // mtc0 EPC dropped by a simultaneous syscall trap
    we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1111;
    exc_code_in = 5'd8; vpc = 32'h0000_3050;
    #1 chk("sys_req", {31'd0, req}, 32'd1);
    tick(); idle();
    chk("sys_epc", epc_out, 32'h0000_3050);
    rd(5'd13, 32'h0000_0020, "sys_cause");

    // req and exl_clr together while EXL = 0: EXL ends at 1
    exl_clr = 1'b1;
    tick(); idle();
    rd(5'd12, 32'h0000_0401, "pre_race_sr");
    exc_code_in = 5'd12; exl_clr = 1'b1; vpc = 32'h0000_3060;
    tick(); idle();
    rd(5'd12, 32'h0000_0403, "race_exl");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Coprocessor-0 block: the receiving end of the execute-stage exception flags (Ov, AdEL, AdES) and of the other per-instruction exception codes.
- Sits beside the M stage.
  - Takes the exception code, victim PC, branch-delay flag and six hardware interrupt lines.
  - Decides whether to take a trap, and latches SR/Cause/EPC.
  - Drives the flush/redirect request to the pipeline.
  - Serves mfc0/mtc0 and eret.

Parameters:
- PRID, 32'h2021_0707, read-only value of register 15.
- HANDLER_PC, 32'h0000_4180, trap vector reported on handler_pc.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- we  in  1  mtc0 write enable (M stage).
- cp0_addr  in  5  register number for read and write.
- cp0_wdata  in  32  mtc0 data.
- cp0_rdata  out  32  mfc0 data, combinational from current registers.
- vpc  in  32  PC of the M-stage instruction, word aligned.
- bd_in  in  1  M-stage instruction sits in a branch delay slot.
- exc_code_in  in  5  pending exception code of the M-stage instruction; 0 = none.
- hw_int  in  6  external interrupt lines, level sensitive.
- exl_clr  in  1  eret in M stage.
- req  out  1  take trap this cycle: flush pipeline and jump to handler_pc.
- handler_pc  out  32  constant HANDLER_PC.
- epc_out  out  32  registered EPC, used by eret.

Behaviour:
Registers:
- SR (12): IM[15:10], EXL[1], IE[0]. Other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]. Other bits read 0.
- EPC (14): 32 bits, bits[1:0] always 0.
- PrID (15): PRID.
- Any other address reads 32'h0.

Reset:
- SR = 0, Cause = 0, EPC = 0.
- req = 0 during reset.
- cp0_rdata follows the reset register values.

Request logic (combinational):
- int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- exc_req = (exc_code_in != 0) & ~SR.EXL.
- req = int_req | exc_req.
- Interrupt has priority over exception.

On a rising edge with req = 1:
- EXL <= 1.
- Cause.ExcCode <= int_req ? 5'd0 : exc_code_in.
- Cause.BD <= bd_in.
- EPC <= bd_in ? vpc - 4 : vpc, with bits[1:0] forced to 0.
- Any mtc0 in the same cycle is discarded, because the instruction is being trapped.

Every cycle:
- Cause.IP <= hw_int, regardless of masks or EXL.

Without req:
- we = 1 writes the addressed register.
- SR keeps only the IM/EXL/IE fields.
- EPC writes force bits[1:0] = 0.
- Cause and PrID writes are ignored.

exl_clr:
- EXL <= 0 at the next edge.
- If mtc0 to SR and exl_clr happen in the same cycle, exl_clr wins for the EXL bit.
- req cannot coincide with a useful exl_clr, since req needs EXL = 0. If both are asserted, req wins and EXL ends at 1.

Timing:
- Read during write returns the old value; the new value is visible the next cycle.
- req is visible in the same cycle as its cause. Register effects are visible the next cycle.

Nesting:
- While EXL = 1, exceptions and interrupts are ignored: req = 0 and no register updates except IP.

Exception code constants:
- Int = 0, AdEL = 4, AdES = 5, Syscall = 8, RI = 10, Ov = 12.

Decomposition:
- Shared macro/package file:
  - exception code constants: EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYSCALL, EXC_RI, EXC_OV.
  - CP0 register numbers: CP0_SR = 12, CP0_CAUSE = 13, CP0_EPC = 14, CP0_PRID = 15.
  - field bit positions.
- The decode/priority stage upstream, which merges ALU Ov/AdEL/AdES and the other codes into exc_code_in, is not part of this block.
- One sub-module is natural: cp0_req_gen, the combinational int_req/exc_req/req and cause-code selection. The register file stays in the top.

Test Plan:
- Reset, then read 12/13/14/15 → 0, 0, 0, PRID. Read 3 → 0.
- mtc0 SR = 32'hFFFF_FFFF, then read → 32'h0000_FC03. mtc0 Cause = 32'hFFFF_FFFF → Cause stays 0.
- Ov trap, SR.EXL = 0: exc_code_in = 12, vpc = 32'h0000_3010, bd_in = 0 → req = 1 that cycle. Next cycle: EPC = 32'h0000_3010, ExcCode = 12, EXL = 1, req = 0 even with exc_code_in = 4 still applied.
- AdES in delay slot: vpc = 32'h0000_3020, bd_in = 1, exc_code_in = 5 → EPC = 32'h0000_301C, Cause = 32'h8000_0014.
- Interrupt vs exception: SR = 32'h0000_0401, hw_int = 6'b000001, exc_code_in = 10 in the same cycle → req = 1, ExcCode = 0, Cause.IP = 6'b000001. With SR.IE = 0, the same stimulus gives ExcCode = 10.
- eret: with EXL = 1, exl_clr = 1 together with mtc0 SR = 32'h0000_0403 → EXL = 0, IE = 1, IM = 6'b000001. mtc0 EPC = 32'h0000_3007 with no req → epc_out = 32'h0000_3004. With req = 1 in the same cycle, the mtc0 is dropped.
